tage_update_ctrl: RTL and testbench

- Initiator side of the TAGE table lookup/update interface.
- Issues lookups to NUM_TABLES tagged tables, then selects the provider and alternate prediction from the table responses.
- Holds in-flight branches in an in-order FIFO.
- On branch resolution, re-presents the branch's index so each table's prev_idx points at the entry, then drives br_result, provider, update_u, dec_u and alloc for that entry.

---
 rtl/tage_update_ctrl_if.sv | 38 +++
 rtl/tage_update_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_tage_update_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tage_update_ctrl_if.sv
// Front-end bus of tage_update_ctrl: lookup request, prediction pulse and branch resolve.
// Also holds tage_pkg (domain_t), shared with the table side.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 10
`endif

package tage_pkg;
   typedef logic [1:0] domain_t;
endpackage

interface tage_update_ctrl_if #(
   parameter int NUM_TABLES = 4,
   parameter int IDX_W      = `TAGE_IDX_WIDTH,
   parameter int TAG_W      = 9
);
   logic                          lk_valid;
   logic                          lk_ready;
   logic [NUM_TABLES*IDX_W-1:0]   lk_idx;
   logic [NUM_TABLES*TAG_W-1:0]   lk_tag;
   tage_pkg::domain_t             lk_domain;
   logic                          base_pred;
   logic                          pred_valid;
   logic                          pred_taken;
   logic                          res_valid;
   logic                          res_ready;
   logic                          res_taken;
   logic [31:0]                   res_targ;

   modport master (
      output lk_valid, lk_idx, lk_tag, lk_domain, base_pred, res_valid, res_taken, res_targ,
      input  lk_ready, pred_valid, pred_taken, res_ready
   );

   modport slave (
      input  lk_valid, lk_idx, lk_tag, lk_domain, base_pred, res_valid, res_taken, res_targ,
      output lk_ready, pred_valid, pred_taken, res_ready
   );
endinterface

// File: rtl/tage_update_ctrl.sv
// TAGE lookup/update initiator: provider/alternate selection, in-order in-flight FIFO, table update.
// Optional macro TAGE_ALLOC_LFSR_EN: LFSR-randomised choice between the two lowest allocation candidates.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 10
`endif

module tage_update_ctrl #(
   parameter int NUM_TABLES = 4,
   parameter int IDX_W      = `TAGE_IDX_WIDTH,
   parameter int TAG_W      = 9,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   tage_update_ctrl_if.slave           bus,
   output logic [NUM_TABLES*IDX_W-1:0] tbl_idx_o,
   output logic [NUM_TABLES*TAG_W-1:0] tbl_tag_o,
   output tage_pkg::domain_t           domain_o,
   output logic [31:0]                 targ_o,
   input  logic [NUM_TABLES-1:0]       tbl_hit_i,
   input  logic [NUM_TABLES-1:0]       tbl_pred_i,
   input  logic [NUM_TABLES-1:0]       tbl_new_i,
   input  logic [2*NUM_TABLES-1:0]     tbl_u_i,
   output logic                        br_result_o,
   output logic                        update_u_o,
   output logic [NUM_TABLES-1:0]       provider_o,
   output logic [NUM_TABLES-1:0]       dec_u_o,
   output logic [NUM_TABLES-1:0]       alloc_o
);
   localparam int DEPTH_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W   = DEPTH_W + 1;
   localparam int P_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
   localparam logic [NUM_TABLES-1:0] ONE_T = {{(NUM_TABLES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LK_RSP, RELOOK, UPDATE} state_t;

   state_t                       r_state, w_state_next;
   logic [PTR_W-1:0]             r_wr_ptr, r_rd_ptr;
   logic                         r_pred_valid, r_pred_taken;
   logic                         r_res_taken;
   logic [31:0]                  r_res_targ;

   logic [NUM_TABLES*IDX_W-1:0]  r_fifo_idx   [FIFO_DEPTH];
   logic [NUM_TABLES*TAG_W-1:0]  r_fifo_tag   [FIFO_DEPTH];
   tage_pkg::domain_t            r_fifo_dom   [FIFO_DEPTH];
   logic                         r_fifo_pv    [FIFO_DEPTH];
   logic [P_W-1:0]               r_fifo_p     [FIFO_DEPTH];
   logic                         r_fifo_ppred [FIFO_DEPTH];
   logic                         r_fifo_apred [FIFO_DEPTH];

   logic                         w_empty, w_full;
   logic                         w_res_ready, w_res_acc, w_lk_ready, w_lk_acc;
   logic [DEPTH_W-1:0]           w_wr_addr, w_rd_addr;
   logic                         w_prov_found, w_alt_found;
   logic [P_W-1:0]               w_prov, w_alt;
   logic                         w_ppred, w_apred;
   logic                         w_head_pv, w_head_ppred, w_head_apred;
   logic [P_W-1:0]               w_head_p;
   logic [NUM_TABLES-1:0]        w_above, w_cand, w_cand_low, w_alloc_sel;
   logic                         w_top_ok, w_mispred;
   logic                         w_unused;

   assign w_unused  = ^tbl_u_i;

   // Wrap bit distinguishes full from empty when the low pointer bits match.
   assign w_wr_addr = r_wr_ptr[DEPTH_W-1:0];
   assign w_rd_addr = r_rd_ptr[DEPTH_W-1:0];
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[DEPTH_W] != r_rd_ptr[DEPTH_W]) && (w_wr_addr == w_rd_addr);

   assign w_res_ready = (r_state == IDLE) && !w_empty;
   assign w_res_acc   = bus.res_valid && w_res_ready;
   assign w_lk_ready  = (r_state == IDLE) && !w_full && !w_res_acc;
   assign w_lk_acc    = bus.lk_valid && w_lk_ready;

   assign bus.res_ready  = w_res_ready;
   assign bus.lk_ready   = w_lk_ready;
   assign bus.pred_valid = r_pred_valid;
   assign bus.pred_taken = r_pred_taken;

   // Ascending scan: each new hit demotes the previous provider to alternate.
   always_comb begin
      w_prov_found = 1'b0;
      w_alt_found  = 1'b0;
      w_prov       = '0;
      w_alt        = '0;
      for (int j = 0; j < NUM_TABLES; j++) begin
         if (tbl_hit_i[j]) begin
            w_alt_found  = w_prov_found;
            w_alt        = w_prov;
            w_prov_found = 1'b1;
            w_prov       = P_W'(j);
         end
      end
   end

   assign w_ppred = w_prov_found ? tbl_pred_i[w_prov] : bus.base_pred;
   assign w_apred = w_alt_found  ? tbl_pred_i[w_alt]  : bus.base_pred;

   assign w_head_pv    = r_fifo_pv[w_rd_addr];
   assign w_head_p     = r_fifo_p[w_rd_addr];
   assign w_head_ppred = r_fifo_ppred[w_rd_addr];
   assign w_head_apred = r_fifo_apred[w_rd_addr];

   generate
      for (genvar gi = 0; gi < NUM_TABLES; gi++) begin : g_above
         assign w_above[gi] = !w_head_pv || (gi > int'(w_head_p));
      end
   endgenerate

   assign w_cand     = tbl_new_i & w_above;
   assign w_cand_low = w_cand & (~w_cand + ONE_T);
   assign w_top_ok   = !w_head_pv || (int'(w_head_p) < NUM_TABLES - 1);
   assign w_mispred  = (w_head_ppred != r_res_taken);

`ifdef TAGE_ALLOC_LFSR_EN
   logic [15:0]           r_lfsr;
   logic [NUM_TABLES-1:0] w_cand_rest, w_cand_2nd;

   assign w_cand_rest = w_cand & ~w_cand_low;
   assign w_cand_2nd  = w_cand_rest & (~w_cand_rest + ONE_T);
   assign w_alloc_sel = ((|w_cand_rest) && r_lfsr[0]) ? w_cand_2nd : w_cand_low;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end
`else
   assign w_alloc_sel = w_cand_low;
`endif

   always_ff @(posedge clk_i) begin
      if (w_lk_acc) begin
         r_fifo_idx[w_wr_addr] <= bus.lk_idx;
         r_fifo_tag[w_wr_addr] <= bus.lk_tag;
         r_fifo_dom[w_wr_addr] <= bus.lk_domain;
      end
      if (r_state == LK_RSP) begin
         r_fifo_pv[w_wr_addr]    <= w_prov_found;
         r_fifo_p[w_wr_addr]     <= w_prov;
         r_fifo_ppred[w_wr_addr] <= w_ppred;
         r_fifo_apred[w_wr_addr] <= w_apred;
      end
   end

   // Tail pointer advances only once the prediction fields of the entry are written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_res_taken  <= 1'b0;
         r_res_targ   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_pred_valid <= (r_state == LK_RSP);
         r_pred_taken <= (r_state == LK_RSP) ? w_ppred : 1'b0;
         if (r_state == LK_RSP) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (r_state == UPDATE) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_res_acc) begin
            r_res_taken <= bus.res_taken;
            r_res_targ  <= bus.res_targ;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      tbl_idx_o    = '0;
      tbl_tag_o    = '0;
      domain_o     = '0;
      targ_o       = '0;
      br_result_o  = 1'b0;
      update_u_o   = 1'b0;
      provider_o   = '0;
      dec_u_o      = '0;
      alloc_o      = '0;
      case (r_state)
         IDLE: begin
            if (w_res_acc) begin
               w_state_next = RELOOK;
            end else if (w_lk_acc) begin
               w_state_next = LK_RSP;
               tbl_idx_o    = bus.lk_idx;
               tbl_tag_o    = bus.lk_tag;
               domain_o     = bus.lk_domain;
            end
         end
         LK_RSP: w_state_next = IDLE;
         RELOOK: begin
            w_state_next = UPDATE;
            tbl_idx_o    = r_fifo_idx[w_rd_addr];
            tbl_tag_o    = r_fifo_tag[w_rd_addr];
            domain_o     = r_fifo_dom[w_rd_addr];
            targ_o       = r_res_targ;
         end
         UPDATE: begin
            w_state_next = IDLE;
            tbl_idx_o    = r_fifo_idx[w_rd_addr];
            tbl_tag_o    = r_fifo_tag[w_rd_addr];
            domain_o     = r_fifo_dom[w_rd_addr];
            targ_o       = r_res_targ;
            br_result_o  = r_res_taken;
            if (w_head_pv) provider_o[w_head_p] = 1'b1;
            update_u_o   = w_head_pv && (w_head_ppred != w_head_apred);
            if (w_mispred && w_top_ok) begin
               if (|w_cand) alloc_o = w_alloc_sel;
               else         dec_u_o = w_above;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_tage_update_ctrl.sv
// Directed bench for tage_update_ctrl: prediction selection, allocation/decay, FIFO full and reset.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 10
`endif

module tb_tage_update_ctrl;
   localparam int NT = 4;
   localparam int IX = `TAGE_IDX_WIDTH;
   localparam int TG = 9;
   localparam int IW = NT * IX;
   localparam int TW = NT * TG;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [IW-1:0]     tbl_idx_o;
   logic [TW-1:0]     tbl_tag_o;
   tage_pkg::domain_t domain_o;
   logic [31:0]       targ_o;
   logic [NT-1:0]     tbl_hit_i, tbl_pred_i, tbl_new_i;
   logic [2*NT-1:0]   tbl_u_i;
   logic              br_result_o, update_u_o;
   logic [NT-1:0]     provider_o, dec_u_o, alloc_o;

   int n_checks = 0;
   int n_pass   = 0;

   tage_update_ctrl_if #(.NUM_TABLES(NT), .IDX_W(IX), .TAG_W(TG)) bus ();

   tage_update_ctrl #(.NUM_TABLES(NT), .IDX_W(IX), .TAG_W(TG), .FIFO_DEPTH(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus),
      .tbl_idx_o(tbl_idx_o), .tbl_tag_o(tbl_tag_o), .domain_o(domain_o), .targ_o(targ_o),
      .tbl_hit_i(tbl_hit_i), .tbl_pred_i(tbl_pred_i), .tbl_new_i(tbl_new_i), .tbl_u_i(tbl_u_i),
      .br_result_o(br_result_o), .update_u_o(update_u_o), .provider_o(provider_o),
      .dec_u_o(dec_u_o), .alloc_o(alloc_o)
   );

   always #5 clk_i = ~clk_i;

   // Lookup held through accept and LK_RSP; returns #1 into the cycle where pred_valid is expected.
   task automatic drive_lookup(input logic [IW-1:0] idx, input logic base,
                               input logic [NT-1:0] hit, input logic [NT-1:0] pred);
      @(negedge clk_i);
      tbl_new_i = '0;
      bus.lk_valid = 1'b1; bus.lk_idx = idx; bus.lk_tag = TW'(idx); bus.lk_domain = 2'd1;
      bus.base_pred = base; tbl_hit_i = hit; tbl_pred_i = pred;
      @(negedge clk_i);
      bus.lk_valid = 1'b0;
      @(negedge clk_i);
      tbl_hit_i = '0; tbl_pred_i = '0; bus.base_pred = 1'b0;
      #1;
      $display("lookup idx=%h base=%b hit=%b pred=%b -> pred_valid=%b taken=%b", idx, base, hit, pred, bus.pred_valid, bus.pred_taken);
   endtask

   // Resolve; captures RELOOK outputs and returns #1 into the UPDATE cycle.
   task automatic drive_resolve(input logic taken, input logic [31:0] targ, input logic [NT-1:0] nw,
                                output logic [IW-1:0] rl_idx, output logic [31:0] rl_targ);
      @(negedge clk_i);
      tbl_new_i = '0;
      bus.res_valid = 1'b1; bus.res_taken = taken; bus.res_targ = targ;
      @(negedge clk_i);
      bus.res_valid = 1'b0; tbl_new_i = nw;
      #1;
      rl_idx = tbl_idx_o; rl_targ = targ_o;
      @(negedge clk_i);
      #1;
      $display("resolve taken=%b new=%b -> prov=%b upd_u=%b alloc=%b dec_u=%b", taken, nw, provider_o, update_u_o, alloc_o, dec_u_o);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      bus.lk_valid = 1'b0; bus.lk_idx = '0; bus.lk_tag = '0; bus.lk_domain = '0; bus.base_pred = 1'b0;
      bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_targ = '0;
      tbl_hit_i = '0; tbl_pred_i = '0; tbl_new_i = '0; tbl_u_i = '0;
      #1;
      n_checks++; if (bus.pred_valid !== 1'b0) $display("FAIL rst_pred_valid got=%b exp=0", bus.pred_valid); else n_pass++;
      n_checks++; if (bus.res_ready !== 1'b0) $display("FAIL rst_res_ready got=%b exp=0", bus.res_ready); else n_pass++;
      n_checks++; if ({br_result_o, update_u_o, provider_o, dec_u_o, alloc_o} !== '0) $display("FAIL rst_update_outs got=%b exp=0", {br_result_o, update_u_o, provider_o, dec_u_o, alloc_o}); else n_pass++;
      n_checks++; if ({tbl_idx_o, targ_o} !== '0) $display("FAIL rst_tbl_outs got=%h exp=0", {tbl_idx_o, targ_o}); else n_pass++;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      n_checks++; if (bus.lk_ready !== 1'b1) $display("FAIL rst_lk_ready got=%b exp=1", bus.lk_ready); else n_pass++;
   endtask

   task automatic test_lookup_no_hit(input string pfx);
      logic [IW-1:0] rl_idx;
      logic [31:0]   rl_targ;
      @(negedge clk_i);
      tbl_new_i = '0;
      bus.lk_valid = 1'b1; bus.lk_idx = 40'h12_3456_789A; bus.lk_tag = 36'h0_ABCD_1234; bus.lk_domain = 2'd2;
      bus.base_pred = 1'b1; tbl_hit_i = '0; tbl_pred_i = '0;
      #1;
      n_checks++; if (bus.lk_ready !== 1'b1) $display("FAIL %s_lk_ready got=%b exp=1", pfx, bus.lk_ready); else n_pass++;
      n_checks++; if (tbl_idx_o !== 40'h12_3456_789A) $display("FAIL %s_lk_idx_pass got=%h exp=123456789a", pfx, tbl_idx_o); else n_pass++;
      n_checks++; if (domain_o !== 2'd2) $display("FAIL %s_lk_domain got=%0d exp=2", pfx, domain_o); else n_pass++;
      @(negedge clk_i);
      bus.lk_valid = 1'b0;
      #1;
      n_checks++; if (bus.pred_valid !== 1'b0) $display("FAIL %s_pred_early got=%b exp=0", pfx, bus.pred_valid); else n_pass++;
      @(negedge clk_i);
      #1;
      $display("lookup idx=%h base=1 hit=0000 -> pred_valid=%b taken=%b", bus.lk_idx, bus.pred_valid, bus.pred_taken);
      n_checks++; if (bus.pred_valid !== 1'b1) $display("FAIL %s_pred_valid got=%b exp=1", pfx, bus.pred_valid); else n_pass++;
      n_checks++; if (bus.pred_taken !== 1'b1) $display("FAIL %s_pred_taken got=%b exp=1", pfx, bus.pred_taken); else n_pass++;
      n_checks++; if (bus.res_ready !== 1'b1) $display("FAIL %s_count1 res_ready got=%b exp=1", pfx, bus.res_ready); else n_pass++;
      @(negedge clk_i);
      bus.base_pred = 1'b0;
      #1;
      n_checks++; if (bus.pred_valid !== 1'b0) $display("FAIL %s_pred_pulse got=%b exp=0", pfx, bus.pred_valid); else n_pass++;
      drive_resolve(1'b1, 32'h1000_0040, 4'b0000, rl_idx, rl_targ);
      n_checks++; if (rl_idx !== 40'h12_3456_789A) $display("FAIL %s_relook_idx got=%h exp=123456789a", pfx, rl_idx); else n_pass++;
      n_checks++; if (rl_targ !== 32'h1000_0040) $display("FAIL %s_relook_targ got=%h exp=10000040", pfx, rl_targ); else n_pass++;
      n_checks++; if ({br_result_o, update_u_o, provider_o, alloc_o, dec_u_o} !== {1'b1, 1'b0, 12'b0}) $display("FAIL %s_update got=%b exp=%b", pfx, {br_result_o, update_u_o, provider_o, alloc_o, dec_u_o}, {1'b1, 13'b0}); else n_pass++;
      @(negedge clk_i);
      #1;
      n_checks++; if ({bus.res_ready, br_result_o} !== 2'b00) $display("FAIL %s_after_pop got=%b exp=00", pfx, {bus.res_ready, br_result_o}); else n_pass++;
   endtask

   task automatic test_provider_top();
      logic [IW-1:0] rl_idx;
      logic [31:0]   rl_targ;
      drive_lookup(40'h00_0000_0222, 1'b1, 4'b1010, 4'b0010);
      n_checks++; if ({bus.pred_valid, bus.pred_taken} !== 2'b10) $display("FAIL top_pred got=%b exp=10", {bus.pred_valid, bus.pred_taken}); else n_pass++;
      drive_resolve(1'b1, 32'h2000_0000, 4'b0000, rl_idx, rl_targ);
      n_checks++; if (provider_o !== 4'b1000) $display("FAIL top_provider got=%b exp=1000", provider_o); else n_pass++;
      n_checks++; if ({update_u_o, br_result_o} !== 2'b11) $display("FAIL top_upd_br got=%b exp=11", {update_u_o, br_result_o}); else n_pass++;
      n_checks++; if ({alloc_o, dec_u_o} !== 8'b0) $display("FAIL top_no_alloc got=%b exp=00000000", {alloc_o, dec_u_o}); else n_pass++;
   endtask

   task automatic test_alloc();
      logic [IW-1:0] rl_idx;
      logic [31:0]   rl_targ;
      drive_lookup(40'h00_0000_0333, 1'b1, 4'b0001, 4'b0000);
      n_checks++; if ({bus.pred_valid, bus.pred_taken} !== 2'b10) $display("FAIL alloc_pred got=%b exp=10", {bus.pred_valid, bus.pred_taken}); else n_pass++;
      drive_resolve(1'b1, 32'h3000_0000, 4'b1010, rl_idx, rl_targ);
      n_checks++; if (rl_idx !== 40'h00_0000_0333) $display("FAIL alloc_relook_idx got=%h exp=333", rl_idx); else n_pass++;
      n_checks++; if ({provider_o, update_u_o} !== 5'b00011) $display("FAIL alloc_prov_upd got=%b exp=00011", {provider_o, update_u_o}); else n_pass++;
      n_checks++; if (alloc_o !== 4'b0010) $display("FAIL alloc_lowest got=%b exp=0010", alloc_o); else n_pass++;
      n_checks++; if (dec_u_o !== 4'b0000) $display("FAIL alloc_dec_u got=%b exp=0000", dec_u_o); else n_pass++;
   endtask

   task automatic test_dec_u();
      logic [IW-1:0] rl_idx;
      logic [31:0]   rl_targ;
      drive_lookup(40'h00_0000_0444, 1'b1, 4'b0001, 4'b0000);
      drive_resolve(1'b1, 32'h4000_0000, 4'b0000, rl_idx, rl_targ);
      n_checks++; if (dec_u_o !== 4'b1110) $display("FAIL dec_u_mask got=%b exp=1110", dec_u_o); else n_pass++;
      n_checks++; if (alloc_o !== 4'b0000) $display("FAIL dec_u_alloc got=%b exp=0000", alloc_o); else n_pass++;
   endtask

   task automatic test_no_provider_alloc();
      logic [IW-1:0] rl_idx;
      logic [31:0]   rl_targ;
      drive_lookup(40'h00_0000_0555, 1'b0, 4'b0000, 4'b0000);
      n_checks++; if ({bus.pred_valid, bus.pred_taken} !== 2'b10) $display("FAIL noprov_pred got=%b exp=10", {bus.pred_valid, bus.pred_taken}); else n_pass++;
      drive_resolve(1'b1, 32'h5000_0000, 4'b0001, rl_idx, rl_targ);
      n_checks++; if ({provider_o, update_u_o} !== 5'b0) $display("FAIL noprov_prov_upd got=%b exp=00000", {provider_o, update_u_o}); else n_pass++;
      n_checks++; if ({alloc_o, dec_u_o} !== 8'b0001_0000) $display("FAIL noprov_alloc got=%b exp=00010000", {alloc_o, dec_u_o}); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) drive_lookup(IW'(k) + 40'h100, 1'b0, 4'b0000, 4'b0000);
      n_checks++; if ({bus.lk_ready, bus.res_ready} !== 2'b01) $display("FAIL full_ready got=%b exp=01", {bus.lk_ready, bus.res_ready}); else n_pass++;
      bus.lk_valid = 1'b1; bus.lk_idx = 40'h1FF; bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.res_targ = 32'h6000_0000;
      #1;
      n_checks++; if (bus.lk_ready !== 1'b0) $display("FAIL full_both_lk_ready got=%b exp=0", bus.lk_ready); else n_pass++;
      @(negedge clk_i);
      bus.res_valid = 1'b0;
      #1;
      $display("resolve taken=0 with lookup pending -> relook idx=%h", tbl_idx_o);
      n_checks++; if (tbl_idx_o !== 40'h100) $display("FAIL full_relook_head got=%h exp=100", tbl_idx_o); else n_pass++;
      @(negedge clk_i);
      #1;
      n_checks++; if ({bus.lk_ready, br_result_o, alloc_o, dec_u_o} !== 10'b0) $display("FAIL full_update got=%b exp=0", {bus.lk_ready, br_result_o, alloc_o, dec_u_o}); else n_pass++;
      @(negedge clk_i);
      #1;
      n_checks++; if (bus.lk_ready !== 1'b1) $display("FAIL full_lk_ready_back got=%b exp=1", bus.lk_ready); else n_pass++;
      n_checks++; if (tbl_idx_o !== 40'h1FF) $display("FAIL full_lk_idx got=%h exp=1ff", tbl_idx_o); else n_pass++;
      bus.res_valid = 1'b1;
      #1;
      n_checks++; if ({bus.lk_ready, bus.res_ready} !== 2'b01) $display("FAIL res_priority got=%b exp=01", {bus.lk_ready, bus.res_ready}); else n_pass++;
      @(negedge clk_i);
      bus.res_valid = 1'b0;
      #1;
      n_checks++; if (tbl_idx_o !== 40'h101) $display("FAIL prio_relook_head got=%h exp=101", tbl_idx_o); else n_pass++;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      n_checks++; if (bus.lk_ready !== 1'b1) $display("FAIL prio_lk_ready_back got=%b exp=1", bus.lk_ready); else n_pass++;
      @(negedge clk_i);
      bus.lk_valid = 1'b0;
      @(negedge clk_i);
      #1;
      $display("lookup idx=1ff accepted after resolves -> pred_valid=%b", bus.pred_valid);
      n_checks++; if ({bus.pred_valid, bus.pred_taken} !== 2'b10) $display("FAIL late_lookup_pred got=%b exp=10", {bus.pred_valid, bus.pred_taken}); else n_pass++;
   endtask

   task automatic test_reset_midop();
      @(negedge clk_i);
      bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_targ = 32'hDEAD_BEEF;
      @(negedge clk_i);
      bus.res_valid = 1'b0;
      #1;
      n_checks++; if ({tbl_idx_o, targ_o} !== {40'h102, 32'hDEAD_BEEF}) $display("FAIL midrst_relook got=%h exp=102deadbeef", {tbl_idx_o, targ_o}); else n_pass++;
      rst_ni = 1'b0;
      #1;
      $display("reset asserted in RELOOK");
      n_checks++; if ({tbl_idx_o, targ_o, domain_o} !== '0) $display("FAIL midrst_tbl_outs got=%h exp=0", {tbl_idx_o, targ_o, domain_o}); else n_pass++;
      n_checks++; if ({bus.res_ready, bus.pred_valid, br_result_o, provider_o} !== '0) $display("FAIL midrst_ctrl_outs got=%b exp=0", {bus.res_ready, bus.pred_valid, br_result_o, provider_o}); else n_pass++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      n_checks++; if ({bus.res_ready, bus.lk_ready} !== 2'b01) $display("FAIL midrst_fifo_empty got=%b exp=01", {bus.res_ready, bus.lk_ready}); else n_pass++;
      test_lookup_no_hit("after_rst");
   endtask

   initial begin
      test_reset();
      test_lookup_no_hit("no_hit");
      test_provider_top();
      test_alloc();
      test_dec_u();
      test_no_provider_alloc();
      test_back_to_back();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
